// File: rtl/vec_packer_if.sv
// Bus between a beat producer / pair consumer and vec_packer.
//   i_valid/o_ready/i_data/i_last : input beat handshake (a in low half, b in high half)
//   o_vec_valid/i_vec_ready       : packed pair handshake
//   o_a/o_b/o_beats               : packed pair payload and beat count
interface vec_packer_if #(
   parameter int unsigned BIT_WIDTH  = 4,
   parameter int unsigned VEC_SIZE   = 64,
   parameter int unsigned BEAT_ELEMS = 8
);
   localparam int unsigned NBEATS = VEC_SIZE / BEAT_ELEMS;
   localparam int unsigned BEAT_W = 2 * BEAT_ELEMS * BIT_WIDTH;
   localparam int unsigned VEC_W  = VEC_SIZE * BIT_WIDTH;
   localparam int unsigned BCW    = $clog2(NBEATS) + 1;

   logic              i_valid;
   logic              o_ready;
   logic [BEAT_W-1:0] i_data;
   logic              i_last;
   logic              o_vec_valid;
   logic              i_vec_ready;
   logic [VEC_W-1:0]  o_a;
   logic [VEC_W-1:0]  o_b;
   logic [BCW-1:0]    o_beats;

   // Packer side
   modport slave (
      input  i_valid, i_data, i_last, i_vec_ready,
      output o_ready, o_vec_valid, o_a, o_b, o_beats
   );

   // Producer / consumer side
   modport master (
      output i_valid, i_data, i_last, i_vec_ready,
      input  o_ready, o_vec_valid, o_a, o_b, o_beats
   );
endinterface

// File: rtl/vec_packer.sv
// Packs a stream of (a,b) element beats into full-length a/b vectors.
// Two stages: an assembly buffer filled beat by beat, and an output register
// presenting one completed pair with a valid/ready handshake.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : beat input, pair output (see vec_packer_if)
module vec_packer #(
   parameter int unsigned BIT_WIDTH  = 4,
   parameter int unsigned VEC_SIZE   = 64,
   parameter int unsigned BEAT_ELEMS = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   vec_packer_if.slave  bus
);
   localparam int unsigned NBEATS = VEC_SIZE / BEAT_ELEMS;
   localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int unsigned BCW    = $clog2(NBEATS) + 1;
   localparam int unsigned HALF_W = BEAT_ELEMS * BIT_WIDTH;
   localparam int unsigned VEC_W  = VEC_SIZE * BIT_WIDTH;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             asm_full_q, asm_full_d;
   logic [VEC_W-1:0] asm_a_q, asm_a_d, asm_b_q, asm_b_d;
   logic [BCW-1:0]   asm_beats_q, asm_beats_d;
   logic             vec_valid_q, vec_valid_d;
   logic [VEC_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic [BCW-1:0]   out_beats_q, out_beats_d;

   logic accept_c, last_beat_c, xfer_c;

   // Accept and transfer are exclusive: one needs asm_full low, the other high.
   assign accept_c    = bus.i_valid && !asm_full_q;
   assign last_beat_c = (cnt_q == CNT_W'(NBEATS - 1)) || bus.i_last;
   assign xfer_c      = asm_full_q && (!vec_valid_q || bus.i_vec_ready);

   // Next-state logic for both stages
   always_comb begin
      cnt_d       = cnt_q;
      asm_full_d  = asm_full_q;
      asm_a_d     = asm_a_q;
      asm_b_d     = asm_b_q;
      asm_beats_d = asm_beats_q;
      vec_valid_d = vec_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_beats_d = out_beats_q;

      if (accept_c) begin
         // First beat clears the buffers so beats never sent read as zero.
         if (cnt_q == '0) begin
            asm_a_d = '0;
            asm_b_d = '0;
         end
         asm_a_d[32'(cnt_q) * HALF_W +: HALF_W] = bus.i_data[HALF_W-1:0];
         asm_b_d[32'(cnt_q) * HALF_W +: HALF_W] = bus.i_data[2*HALF_W-1:HALF_W];
         if (last_beat_c) begin
            asm_full_d  = 1'b1;
            asm_beats_d = BCW'(cnt_q) + BCW'(1);
            cnt_d       = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (xfer_c) begin
         out_a_d     = asm_a_q;
         out_b_d     = asm_b_q;
         out_beats_d = asm_beats_q;
         vec_valid_d = 1'b1;
         asm_full_d  = 1'b0;
      end else if (vec_valid_q && bus.i_vec_ready) begin
         vec_valid_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q       <= '0;
         asm_full_q  <= 1'b0;
         asm_a_q     <= '0;
         asm_b_q     <= '0;
         asm_beats_q <= '0;
         vec_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_beats_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         asm_full_q  <= asm_full_d;
         asm_a_q     <= asm_a_d;
         asm_b_q     <= asm_b_d;
         asm_beats_q <= asm_beats_d;
         vec_valid_q <= vec_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_beats_q <= out_beats_d;
      end
   end

   assign bus.o_ready     = !asm_full_q;
   assign bus.o_vec_valid = vec_valid_q;
   assign bus.o_a         = out_a_q;
   assign bus.o_b         = out_b_q;
   assign bus.o_beats     = out_beats_q;
endmodule

// File: doc/vec_packer.md
VEC_PACKER -- requirements
Module: vec_packer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4, signed element width.
REQ-002 SHALL have parameter VEC_SIZE, default 64, elements per vector.
REQ-003 SHALL have parameter BEAT_ELEMS, default 8, elements per operand per input beat; VEC_SIZE is an integer multiple of BEAT_ELEMS.
REQ-004 SHALL have the following ports; one clock, reset asynchronous and active-low:
  i_clk  input  1  clock, all state on rising edge
  i_rst_n  input  1  asynchronous active-low reset
  i_valid  input  1  input beat valid
  o_ready  output  1  packer can accept a beat
  i_data  input  2*BEAT_ELEMS*BIT_WIDTH  [BEAT_ELEMS*BIT_WIDTH-1:0] = a elements, upper half = b elements, element k at k*BIT_WIDTH
  i_last  input  1  final beat of current vector pair
  o_vec_valid  output  1  packed vector pair valid
  i_vec_ready  input  1  downstream accepts pair
  o_a  output  VEC_SIZE*BIT_WIDTH  flattened a vector, element j at j*BIT_WIDTH
  o_b  output  VEC_SIZE*BIT_WIDTH  flattened b vector, same layout
  o_beats  output  $clog2(VEC_SIZE/BEAT_ELEMS)+1  beats received for the presented pair, 1..VEC_SIZE/BEAT_ELEMS

Function
REQ-005 SHALL contain an assembly stage (a/b buffers, beat counter cnt, flag asm_full) and an output register stage (o_a, o_b, o_beats, o_vec_valid).
REQ-006 SHALL drive o_ready = !asm_full (registered state only; no combinational path from i_vec_ready).
REQ-007 SHALL accept a beat iff i_valid && o_ready at a rising edge; i_data and i_last are ignored otherwise.
REQ-008 SHALL write accepted beat at cnt into element positions cnt*BEAT_ELEMS .. cnt*BEAT_ELEMS+BEAT_ELEMS-1 of both buffers, then increment cnt.
REQ-009 SHALL, on a beat accepted with cnt==0, zero every buffer position outside beat 0, so unsent beats read as zero.
REQ-010 SHALL complete the assembly when the accepted beat has cnt==VEC_SIZE/BEAT_ELEMS-1 or i_last==1: set asm_full, latch beat count cnt+1, reset cnt to 0.
REQ-011 SHALL transfer assembly to output register when asm_full && (!o_vec_valid || i_vec_ready): load o_a, o_b, o_beats, set o_vec_valid, clear asm_full, same edge.
REQ-012 SHALL clear o_vec_valid when o_vec_valid && i_vec_ready and no transfer occurs on that edge.
REQ-013 SHALL hold o_a, o_b, o_beats stable while o_vec_valid && !i_vec_ready.
REQ-014 SHALL have latency: completing beat accepted at edge N -> o_ready low after N; o_vec_valid high after N+1 when output stage empty or drained at N+1.
REQ-015 SHALL sustain one full-length pair per VEC_SIZE/BEAT_ELEMS+1 cycles with i_valid and i_vec_ready held high.
REQ-016 SHALL treat i_last on the first beat as a 1-beat vector (o_beats=1, remaining elements zero).
REQ-017 SHALL pass elements bit-exact; no sign extension or arithmetic; signedness is downstream's concern.
REQ-018 SHALL not lose or duplicate a pair under any i_vec_ready pattern, including i_vec_ready toggling every cycle.

Reset
REQ-019 SHALL on i_rst_n low, asynchronously: o_vec_valid=0, asm_full=0, cnt=0, o_a=0, o_b=0, o_beats=0; o_ready=1 once reset released.
REQ-020 SHALL discard a partially assembled vector or unaccepted output pair when reset asserts mid-operation; first beat after release goes to position 0.

Verification
REQ-021 Full vector: 8 beats, beat k a-elements all k, b-elements all -k, i_vec_ready=1 -> o_vec_valid one cycle, 2 cycles after beat 7; o_a element j = j/8, o_b = -(j/8); o_beats=8.
REQ-022 Short vector: 3 beats of 0x7 elements, i_last on beat 2 -> o_beats=3, elements 0..23 = 0x7, 24..63 = 0.
REQ-023 Backpressure: i_vec_ready=0, send two full pairs -> first presented and held stable; o_ready stays low after second completes; raise i_vec_ready -> pairs delivered in order, no loss.
REQ-024 Streaming: i_valid and i_vec_ready constant 1, 10 pairs -> one pair every 9 cycles, each pair matches its input.
REQ-025 Reset mid-vector: 4 beats sent, pulse i_rst_n low -> o_vec_valid=0 immediately; next 8 beats produce a pair with no residue from the aborted beats.
REQ-026 Random i_valid/i_vec_ready/i_last over 1000 pairs against a scoreboard -> every pair matches, o_beats correct, stability rule (REQ-013) never violated.
